// File: rtl/miri_pkg.sv
// Shared fetch-side types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package miri_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_1000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register with +4 advance and redirect mux; FETCH_MISALIGN_EN keeps low target bits.
// Latency: new PC visible one cycle after redirect/advance.
// Backpressure: none; redirect wins over advance.
module fetch_pc_gen
    import miri_pkg::*;
#(
    parameter int                ADDR_W   = XLEN,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_vld,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] target;

`ifdef FETCH_MISALIGN_EN
    assign target = redirect_pc;
`else
    // Targets are word-forced so the fetch address stays aligned.
    assign target = redirect_pc & ~ADDR_W'(3);
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_vld) begin
            pc_d = target;
        end else if (advance) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM; FETCH_MISALIGN_EN enables misaligned-target exception.
// Latency: accept in N, response in N+1 -> instr_valid in N+2 (one instr per 3 cycles).
// Backpressure: holds instruction until decode_ready; redirect flushes and drains in-flight response.
module fetch_unit
    import miri_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = XLEN
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               decode_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_exc
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_vld_q, instr_vld_d;
    logic               exc_q, exc_d;
    logic               pc_advance;
    logic               redirect_misalign;
    logic [ADDR_W-1:0]  pc;

`ifdef FETCH_MISALIGN_EN
    assign redirect_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_misalign = 1'b0;
`endif

    fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_gen (
        .clk          (clk),
        .reset        (reset),
        .redirect_vld (redirect_valid),
        .redirect_pc  (redirect_pc),
        .advance      (pc_advance),
        .pc           (pc)
    );

    // Gated by reset so no request leaks out while the core is held in reset.
    assign imem_req  = reset && (state_q == ST_REQ) && !exc_q;
    assign imem_addr = pc;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        instr_vld_d = instr_vld_q;
        exc_d       = exc_q;
        pc_advance  = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    state_d = (imem_req && imem_ready) ? ST_DRAIN : ST_REQ;
                end else if (imem_req && imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_d     = ST_HOLD;
                    instr_d     = imem_rsp_data;
                    instr_pc_d  = pc;
                    instr_vld_d = 1'b1;
                    pc_advance  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || decode_ready) begin
                    state_d     = ST_REQ;
                    instr_vld_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // A redirect here only retargets the PC; the stale response is still owed.
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect_valid) begin
            instr_vld_d = 1'b0;
            exc_d       = redirect_misalign;
            if (redirect_misalign) begin
                instr_pc_d = redirect_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_REQ;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            instr_vld_q <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            instr_vld_q <= instr_vld_d;
            exc_q       <= exc_d;
        end
    end

    assign instruction = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_vld_q;
    assign fetch_exc   = exc_q;

endmodule
